// File: rtl/parity_page_receiver.sv
// parity_page_receiver: captures a PAGES-word burst, rechecks XOR parity, streams the data words out over valid/ack
module parity_page_receiver #(
  parameter int WIDTH = 32,
  parameter int PAGES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_in_ready,
  input  logic [WIDTH-1:0] i_data_in,
  output logic             o_ready,
  output logic             o_done,
  output logic             o_parity_err,
  output logic             o_overrun,
  output logic             o_out_valid,
  output logic [WIDTH-1:0] o_out_data,
  input  logic             i_out_ack
);
  localparam int CW = $clog2(PAGES);
  localparam logic [CW-1:0] LAST = CW'(PAGES - 1);
  typedef enum logic [1:0] {IDLE, CAPTURE, CHECK, DRAIN} state_t;
  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_buf [PAGES];
  logic [CW-1:0]    w_cnt_inc;
  logic [WIDTH-1:0] w_acc_next;
  assign w_cnt_inc  = r_cnt + CW'(1);
  assign w_acc_next = r_acc ^ i_data_in;
  always_ff @(posedge clk)
    if (r_state == CAPTURE) r_buf[r_cnt] <= i_data_in;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_acc        <= '0;
      o_ready      <= 1'b1;
      o_done       <= 1'b0;
      o_parity_err <= 1'b0;
      o_overrun    <= 1'b0;
      o_out_valid  <= 1'b0;
      o_out_data   <= '0;
    end else begin
      o_done <= 1'b0;
      if (i_in_ready && r_state != IDLE) o_overrun <= 1'b1;
      case (r_state)
        IDLE: if (i_in_ready) begin
          r_state      <= CAPTURE;
          r_cnt        <= '0;
          r_acc        <= '0;
          o_parity_err <= 1'b0;
          o_ready      <= 1'b0;
        end
        CAPTURE: begin
          r_acc <= w_acc_next;
          if (r_cnt == LAST) begin
            o_parity_err <= |w_acc_next;
            o_done       <= 1'b1;
            r_state      <= CHECK;
          end else r_cnt <= w_cnt_inc;
        end
        CHECK: begin
          r_cnt       <= CW'(1);
          o_out_valid <= 1'b1;
          o_out_data  <= r_buf[CW'(1)];
          r_state     <= DRAIN;
        end
        DRAIN: if (i_out_ack) begin
          if (r_cnt == LAST) begin
            o_out_valid <= 1'b0;
            o_ready     <= 1'b1;
            r_state     <= IDLE;
          end else begin
            r_cnt      <= w_cnt_inc;
            o_out_data <= r_buf[w_cnt_inc];
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_parity_page_receiver.sv
// tb_parity_page_receiver: directed scoreboard bench for parity_page_receiver (PAGES=8/WIDTH=32 and PAGES=2/WIDTH=8)
module tb_parity_page_receiver;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic a_in_ready = 1'b0, a_ack = 1'b0;
  logic [31:0] a_data_in = '0;
  logic a_ready, a_done, a_perr, a_ovr, a_valid;
  logic [31:0] a_data;
  logic b_in_ready = 1'b0, b_ack = 1'b0;
  logic [7:0] b_data_in = '0;
  logic b_ready, b_done, b_perr, b_ovr, b_valid;
  logic [7:0] b_data;
  parity_page_receiver #(.WIDTH(32), .PAGES(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .i_in_ready(a_in_ready), .i_data_in(a_data_in),
    .o_ready(a_ready), .o_done(a_done), .o_parity_err(a_perr), .o_overrun(a_ovr),
    .o_out_valid(a_valid), .o_out_data(a_data), .i_out_ack(a_ack));
  parity_page_receiver #(.WIDTH(8), .PAGES(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .i_in_ready(b_in_ready), .i_data_in(b_data_in),
    .o_ready(b_ready), .o_done(b_done), .o_parity_err(b_perr), .o_overrun(b_ovr),
    .o_out_valid(b_valid), .o_out_data(b_data), .i_out_ack(b_ack));
  int n_cmp = 0, n_err = 0;
  logic [31:0] a_q[$];
  logic [7:0]  b_q[$];
  logic a_pv = 1'b0, a_pa = 1'b0;
  logic [31:0] a_pd = '0;
  logic [31:0] w1 [8];
  logic [31:0] w2 [8];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    if (a_valid && a_ack) begin
      if (a_q.size() == 0) chk("a_extra_word", a_data, 32'hffff_ffff);
      else chk("a_word", a_data, a_q.pop_front());
    end
    if (b_valid && b_ack) begin
      if (b_q.size() == 0) chk("b_extra_word", {24'd0, b_data}, 32'hffff_ffff);
      else chk("b_word", {24'd0, b_data}, {24'd0, b_q.pop_front()});
    end
    if (a_pv && !a_pa) begin
      chk("hold_valid", a_valid, 1);
      chk("hold_data", a_data, a_pd);
    end
    a_pv = a_valid;
    a_pa = a_ack;
    a_pd = a_data;
    @(posedge clk);
    #1;
  endtask
  task automatic send_burst(input logic [31:0] w [8], input int pulse_at);
    a_in_ready = 1'b1;
    tick();
    chk("perr_cleared", a_perr, 0);
    for (int i = 0; i < 8; i++) begin
      a_data_in = w[i];
      a_in_ready = (i == pulse_at);
      if (i > 0) a_q.push_back(w[i]);
      tick();
    end
    a_in_ready = 1'b0;
    a_data_in = $urandom;
  endtask
  task automatic drain(input int mode, input int ovr_at, output int cycles);
    int c;
    for (c = 0; c < 200 && a_q.size() > 0; c++) begin
      a_ack = (mode == 0) ? 1'b1 : (c % 3 == 0);
      a_in_ready = (c == ovr_at);
      tick();
    end
    a_ack = 1'b0;
    a_in_ready = 1'b0;
    cycles = c;
    chk("drain_empty", a_q.size(), 0);
    chk("ready_back", a_ready, 1);
    chk("valid_low", a_valid, 0);
  endtask
  initial begin
    int cyc;
    for (int i = 1; i < 8; i++) w1[i] = i;
    w1[0] = 32'h0;
    w2 = w1;
    w2[3] = w2[3] ^ 32'h1;
    #12;
    chk("rst_ready", a_ready, 1);
    chk("rst_done", a_done, 0);
    chk("rst_perr", a_perr, 0);
    chk("rst_ovr", a_ovr, 0);
    chk("rst_valid", a_valid, 0);
    chk("rst_data", a_data, 0);
    rst_n = 1'b1;
    tick();
    tick();
    // good parity, ack tied high
    send_burst(w1, -1);
    chk("t1_done", a_done, 1);
    chk("t1_ready", a_ready, 0);
    chk("t1_valid_chk", a_valid, 0);
    chk("t1_perr", a_perr, 0);
    tick();
    chk("t1_done_pulse", a_done, 0);
    chk("t1_first_valid", a_valid, 1);
    chk("t1_first_data", a_data, 1);
    drain(0, -1, cyc);
    chk("t1_drain_cycles", cyc, 7);
    // flipped bit: error held through drain and idle
    send_burst(w2, -1);
    chk("t2_done", a_done, 1);
    chk("t2_perr", a_perr, 1);
    drain(0, -1, cyc);
    chk("t2_perr_drain", a_perr, 1);
    for (int i = 0; i < 3; i++) tick();
    chk("t2_perr_idle", a_perr, 1);
    // ack toggling 1,0,0,1
    send_burst(w1, -1);
    chk("t3_perr", a_perr, 0);
    tick();
    drain(1, -1, cyc);
    chk("t3_ovr", a_ovr, 0);
    // overrun pulses in capture and drain
    send_burst(w1, 2);
    chk("t4_ovr_cap", a_ovr, 1);
    chk("t4_done", a_done, 1);
    chk("t4_perr", a_perr, 0);
    tick();
    drain(0, 3, cyc);
    chk("t4_drain_cycles", cyc, 7);
    chk("t4_ovr_sticky", a_ovr, 1);
    // async reset mid-capture
    a_in_ready = 1'b1;
    tick();
    a_in_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_data_in = w2[i];
      tick();
    end
    a_data_in = w2[4];
    rst_n = 1'b0;
    #1;
    chk("t5_ovr", a_ovr, 0);
    chk("t5_perr", a_perr, 0);
    chk("t5_done", a_done, 0);
    chk("t5_valid", a_valid, 0);
    chk("t5_data", a_data, 0);
    chk("t5_ready", a_ready, 1);
    a_pv = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("t5_idle_ready", a_ready, 1);
    send_burst(w1, -1);
    chk("t5_done2", a_done, 1);
    chk("t5_perr2", a_perr, 0);
    drain(0, -1, cyc);
    // PAGES=2, WIDTH=8
    b_in_ready = 1'b1;
    tick();
    b_in_ready = 1'b0;
    b_data_in = 8'hA5;
    tick();
    b_q.push_back(8'hA5);
    tick();
    chk("t6_done", b_done, 1);
    chk("t6_perr", b_perr, 0);
    b_ack = 1'b1;
    for (int c = 0; c < 20 && b_q.size() > 0; c++) tick();
    b_ack = 1'b0;
    chk("t6_empty", b_q.size(), 0);
    chk("t6_ready", b_ready, 1);
    chk("t6_valid", b_valid, 0);
    chk("t6_data", {24'd0, b_data}, 32'hA5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
